acc_result_serializer: RTL and testbench

ACC_RESULT_SERIALIZER -- requirements
Module: acc_result_serializer

---
 rtl/acc_result_serializer_pkg.sv | 42 ++++
 rtl/acc_result_fifo.sv | 60 ++++++
 rtl/acc_result_serializer.sv | 134 +++++++++++++
 tb/tb_acc_result_serializer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_result_serializer_pkg.sv
// Shared definitions for the accumulator result serializer: mode tags, widths,
// FIFO entry layout and the mode-to-lane helpers.
package acc_result_serializer_pkg;

  localparam int LANE_W  = 16;
  localparam int WORD_W  = 64;
  localparam int MODE_W  = 2;
  localparam int ENTRY_W = WORD_W + MODE_W;
  localparam int LCNT_W  = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_X4  = 2'b00,
    MODE_X2  = 2'b01,
    MODE_BAD = 2'b10,
    MODE_X1  = 2'b11
  } mode_e;

  typedef struct packed {
    mode_e              mode;
    logic [WORD_W-1:0]  data;
  } fifo_entry_t;

  function automatic logic [LCNT_W-1:0] lane_count(input mode_e mode);
    case (mode)
      MODE_X4: return LCNT_W'(4);
      MODE_X2: return LCNT_W'(2);
      MODE_X1: return LCNT_W'(1);
      default: return LCNT_W'(0);
    endcase
  endfunction

  // Left-justify the valid lanes so the serializer always emits the top lane.
  function automatic logic [WORD_W-1:0] align_word(input mode_e mode,
                                                   input logic [WORD_W-1:0] data);
    case (mode)
      MODE_X2: return {data[2*LANE_W-1:0], {(WORD_W-2*LANE_W){1'b0}}};
      MODE_X1: return {data[LANE_W-1:0],   {(WORD_W-LANE_W){1'b0}}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/acc_result_fifo.sv
// DEPTH-entry FIFO for tagged result words; full/empty come from a pointer
// wrap bit, and push+pop is legal at any occupancy.
module acc_result_fifo
  import acc_result_serializer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // When empty, a simultaneous push+pop hands the incoming word straight through.
  assign w_do_pop  = i_pop  & (~w_empty | i_push);
  assign w_do_push = i_push & (~w_full  | i_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // decide which entries are meaningful, and an unreset array maps to RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  assign o_rd_data = w_empty ? i_wr_data : r_mem[r_rd_ptr[AW-1:0]];
  assign o_full    = w_full;
  assign o_empty   = w_empty;

endmodule

// File: rtl/acc_result_serializer.sv
// Queues 64-bit accumulator results and emits them as 16-bit lanes through a
// registered valid/ready output stage; mode 10 words are dropped and counted.
module acc_result_serializer
  import acc_result_serializer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MODE_W-1:0] en,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [LANE_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [7:0]        drop_cnt
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e            r_state;
  state_e            w_state_nxt;

  fifo_entry_t       w_wr_entry;
  fifo_entry_t       w_head;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_accept;
  logic              w_push;
  logic              w_drop;
  logic              w_pop;

  logic [WORD_W-1:0] r_shift;
  logic [LCNT_W-1:0] r_lane_cnt;
  logic              r_out_valid;
  logic [LANE_W-1:0] r_out_data;
  logic              r_out_last;
  logic [7:0]        r_drop_cnt;

  logic              w_out_adv;
  logic              w_lane_move;
  logic              w_last_move;

  assign w_accept   = in_valid & in_ready;
  assign w_drop     = w_accept & (en == MODE_BAD);
  assign w_push     = w_accept & (en != MODE_BAD);
  assign w_wr_entry = '{mode: mode_e'(en), data: in_data};

  acc_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wr_data (w_wr_entry),
    .o_rd_data (w_head),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  // A lane moves from the shift register into the output register whenever
  // that register is empty or its current lane is being taken downstream.
  assign w_out_adv   = ~r_out_valid | out_ready;
  assign w_lane_move = (r_state == SEND) & w_out_adv;
  assign w_last_move = w_lane_move & (r_lane_cnt == LCNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_last_move) begin
          if (!w_fifo_empty) w_pop       = 1'b1;
          else               w_state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_lane_cnt <= '0;
    end else if (w_pop) begin
      r_shift    <= align_word(w_head.mode, w_head.data);
      r_lane_cnt <= lane_count(w_head.mode);
    end else if (w_lane_move) begin
      r_shift    <= {r_shift[WORD_W-LANE_W-1:0], {LANE_W{1'b0}}};
      r_lane_cnt <= r_lane_cnt - 1'b1;
    end
  end

  // Output register only changes when free or accepted, so a stalled lane holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_out_adv) begin
      r_out_valid <= w_lane_move;
      r_out_data  <= w_lane_move ? r_shift[WORD_W-1 -: LANE_W] : '0;
      r_out_last  <= w_last_move;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 1'b1;
  end

  assign in_ready  = ~w_fifo_full;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_acc_result_serializer.sv
// Directed bench for acc_result_serializer: a single-word vector table plus
// hand-written back-to-back, backpressure, drop-saturation and reset sequences.
module tb_acc_result_serializer;
  import acc_result_serializer_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  en;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic [7:0]  drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  acc_result_serializer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt)
  );

  typedef struct packed {
    logic [1:0]        mode;
    logic [63:0]       data;
    logic [2:0]        n_lanes;
    logic [0:3][15:0]  lanes;
  } vec_t;

  vec_t        vecs [7];
  logic [15:0] c_exp [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int idx, input logic [1:0] m, input logic [63:0] d,
                         input logic [2:0] n, input logic [15:0] l0, input logic [15:0] l1,
                         input logic [15:0] l2, input logic [15:0] l3);
    vecs[idx].mode    = m;
    vecs[idx].data    = d;
    vecs[idx].n_lanes = n;
    vecs[idx].lanes   = {l0, l1, l2, l3};
  endtask

  // Returns #1 after the edge that accepted the word.
  task automatic push_word(input logic [1:0] m, input logic [63:0] d);
    int guard = 0;
    in_valid = 1'b1;
    en       = m;
    in_data  = d;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) check("push in_ready timeout", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    en       = 2'b00;
    in_data  = '0;
  endtask

  function automatic logic [15:0] b_lane(input int i, input int j);
    return 16'((i + 1) * 4096 + j);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          exp_drop;
    int          idx;
    logic        stalled;
    logic [15:0] held_d;
    logic        held_l;
    logic        seen;

    rst       = 1'b1;
    en        = 2'b00;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    exp_drop  = 0;

    set_vec(0, 2'b00, 64'h1111_2222_3333_4444, 3'd4, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    set_vec(1, 2'b01, 64'h0000_0000_AAAA_5555, 3'd2, 16'hAAAA, 16'h5555, 16'h0, 16'h0);
    set_vec(2, 2'b11, 64'hFFFF_FFFF_FFFF_0007, 3'd1, 16'h0007, 16'h0, 16'h0, 16'h0);
    set_vec(3, 2'b01, 64'hDEAD_BEEF_1234_5678, 3'd2, 16'h1234, 16'h5678, 16'h0, 16'h0);
    set_vec(4, 2'b00, 64'h0123_4567_89AB_CDEF, 3'd4, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF);
    set_vec(5, 2'b10, 64'h1234_5678_9ABC_DEF0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0);
    set_vec(6, 2'b11, 64'h8000_0000_0000_FFFF, 3'd1, 16'hFFFF, 16'h0, 16'h0, 16'h0);

    // Reset state
    tick();
    tick();
    check("rst out_valid", out_valid, 1'b0);
    check("rst out_data",  out_data,  16'h0);
    check("rst out_last",  out_last,  1'b0);
    check("rst drop_cnt",  drop_cnt,  8'd0);
    rst = 1'b0;
    tick();
    check("post-rst in_ready", in_ready, 1'b1);

    // Table: one word at a time, out_ready high, latency and lane order
    for (int v = 0; v < 7; v++) begin
      push_word(vecs[v].mode, vecs[v].data);
      check($sformatf("v%0d valid after accept", v), out_valid, 1'b0);
      tick();
      check($sformatf("v%0d valid after t+1", v), out_valid, 1'b0);
      tick();
      if (vecs[v].n_lanes == 3'd0) begin
        exp_drop++;
        check($sformatf("v%0d dropped valid", v), out_valid, 1'b0);
        check($sformatf("v%0d drop_cnt", v), drop_cnt, 8'(exp_drop));
      end else begin
        for (int k = 0; k < int'(vecs[v].n_lanes); k++) begin
          check($sformatf("v%0d lane%0d valid", v, k), out_valid, 1'b1);
          check($sformatf("v%0d lane%0d data", v, k), out_data, vecs[v].lanes[k]);
          check($sformatf("v%0d lane%0d last", v, k), out_last, (k == int'(vecs[v].n_lanes) - 1));
          tick();
        end
      end
      check($sformatf("v%0d idle valid", v), out_valid, 1'b0);
      check($sformatf("v%0d idle data", v),  out_data,  16'h0);
    end

    // Back-to-back mode 01 then mode 11 with no bubble
    push_word(2'b01, 64'h0000_0000_AAAA_5555);
    push_word(2'b11, 64'h1234_5678_9ABC_0007);
    tick();
    check("b2b l0 data", out_data, 16'hAAAA);
    check("b2b l0 last", out_last, 1'b0);
    tick();
    check("b2b l1 data", out_data, 16'h5555);
    check("b2b l1 last", out_last, 1'b1);
    tick();
    check("b2b l2 valid", out_valid, 1'b1);
    check("b2b l2 data",  out_data,  16'h0007);
    check("b2b l2 last",  out_last,  1'b1);
    tick();
    check("b2b end valid", out_valid, 1'b0);

    // Five words with out_ready low fill FIFO plus shift register
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push_word(2'b00, {b_lane(i, 0), b_lane(i, 1), b_lane(i, 2), b_lane(i, 3)});
    check("full in_ready", in_ready, 1'b0);
    tick();
    tick();
    check("full in_ready held", in_ready, 1'b0);
    check("full held data", out_data, b_lane(0, 0));
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      check($sformatf("drain%0d valid", k), out_valid, 1'b1);
      check($sformatf("drain%0d data", k),  out_data,  b_lane(k / 4, k % 4));
      check($sformatf("drain%0d last", k),  out_last,  (k % 4) == 3);
      tick();
    end
    check("drain end valid", out_valid, 1'b0);
    check("drain end in_ready", in_ready, 1'b1);

    // out_ready toggling every cycle during a mode 00 word
    c_exp[0] = 16'hCAFE;
    c_exp[1] = 16'hBEEF;
    c_exp[2] = 16'hF00D;
    c_exp[3] = 16'h1234;
    out_ready = 1'b0;
    push_word(2'b00, 64'hCAFE_BEEF_F00D_1234);
    idx     = 0;
    stalled = 1'b0;
    held_d  = '0;
    held_l  = 1'b0;
    for (int cyc = 0; cyc < 40 && idx < 4; cyc++) begin
      out_ready = (cyc % 2) == 1;
      if (stalled) begin
        check($sformatf("toggle hold valid c%0d", cyc), out_valid, 1'b1);
        check($sformatf("toggle hold data c%0d", cyc),  out_data,  held_d);
        check($sformatf("toggle hold last c%0d", cyc),  out_last,  held_l);
      end
      if (out_valid && out_ready) begin
        check($sformatf("toggle lane%0d data", idx), out_data, c_exp[idx]);
        check($sformatf("toggle lane%0d last", idx), out_last, idx == 3);
        idx++;
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled = 1'b1;
        held_d  = out_data;
        held_l  = out_last;
      end else begin
        stalled = 1'b0;
      end
      tick();
    end
    check("toggle lanes retired", idx, 4);
    out_ready = 1'b1;
    tick();
    check("toggle end valid", out_valid, 1'b0);

    // 300 mode 10 words saturate drop_cnt and emit nothing
    seen     = 1'b0;
    in_valid = 1'b1;
    en       = 2'b10;
    in_data  = 64'h5A5A_5A5A_5A5A_5A5A;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    in_valid = 1'b0;
    en       = 2'b00;
    tick();
    tick();
    if (out_valid) seen = 1'b1;
    check("drop no out_valid", seen, 1'b0);
    check("drop_cnt saturated", drop_cnt, 8'd255);

    // Reset mid-word with a second word queued behind it
    push_word(2'b00, 64'h1111_2222_3333_4444);
    push_word(2'b00, 64'h5555_6666_7777_8888);
    tick();
    tick();
    tick();
    check("midrst pre data", out_data, 16'h3333);
    rst = 1'b1;
    #1;
    check("midrst valid", out_valid, 1'b0);
    check("midrst data",  out_data,  16'h0);
    check("midrst last",  out_last,  1'b0);
    check("midrst drop_cnt", drop_cnt, 8'd0);
    tick();
    rst = 1'b0;
    tick();
    check("midrst in_ready", in_ready, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("midrst no residue", seen, 1'b0);
    push_word(2'b11, 64'h0000_0000_0000_BEEF);
    tick();
    check("midrst fresh t+1 valid", out_valid, 1'b0);
    tick();
    check("midrst fresh valid", out_valid, 1'b1);
    check("midrst fresh data",  out_data,  16'hBEEF);
    check("midrst fresh last",  out_last,  1'b1);
    tick();
    check("midrst fresh end", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
